// File: rtl/axis_framer.sv
// Frames an unframed sample stream into AXI4-Stream packets of programmable length,
// registered through a 2-entry skid buffer. Optional counters: PIRADIP_AXIS_FRAMER_STATS_EN.
//   state   | meaning
//   IDLE    | no packet open; next accepted beat starts one
//   PKT     | packet open; remain_q = beats left including the current one
module axis_framer #(
    parameter int WIDTH      = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [ID_WIDTH-1:0]   pkt_id,
    input  logic [DEST_WIDTH-1:0] pkt_dest,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [WIDTH-1:0]      s_tdata,
    input  logic                  s_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [WIDTH-1:0]      m_tdata,
    output logic                  m_tlast,
    output logic [WIDTH/8-1:0]    m_tkeep,
    output logic [WIDTH/8-1:0]    m_tstrb,
    output logic [ID_WIDTH-1:0]   m_tid,
    output logic [DEST_WIDTH-1:0] m_tdest
`ifdef PIRADIP_AXIS_FRAMER_STATS_EN
    ,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_short
`endif
);

    localparam int KW = WIDTH / 8;
    localparam int PW = WIDTH + 1 + ID_WIDTH + DEST_WIDTH;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;
    localparam logic [LEN_WIDTH:0] ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

    logic [0:0]            state_q, state_d;
    logic [LEN_WIDTH:0]    remain_q, remain_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic                  main_vld_q, main_vld_d;
    logic                  skid_vld_q, skid_vld_d;
    logic                  rdy_q, rdy_d;
    logic [PW-1:0]         main_q, main_d;
    logic [PW-1:0]         skid_q, skid_d;

    logic                  accept;
    logic                  nat_last;
    logic                  beat_last;
    logic [LEN_WIDTH:0]    len_eff;
    logic [ID_WIDTH-1:0]   beat_id;
    logic [DEST_WIDTH-1:0] beat_dest;
    logic [PW-1:0]         beat;

    assign accept = s_tvalid && rdy_q;

    always_comb begin
        len_eff   = (pkt_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, pkt_len};
        state_d   = state_q;
        remain_d  = remain_q;
        id_d      = id_q;
        dest_d    = dest_q;
        beat_id   = id_q;
        beat_dest = dest_q;
        if (state_q == ST_IDLE) begin
            nat_last  = (len_eff == ONE);
            beat_id   = pkt_id;
            beat_dest = pkt_dest;
        end else begin
            nat_last  = (remain_q == ONE);
        end
        beat_last = nat_last || s_tlast;
        // last-beat detection precedes the decrement, so remain_q never underflows
        if (accept) begin
            if (state_q == ST_IDLE) begin
                id_d     = pkt_id;
                dest_d   = pkt_dest;
                remain_d = len_eff - ONE;
            end else if (!beat_last) begin
                remain_d = remain_q - ONE;
            end
            state_d = beat_last ? ST_IDLE : ST_PKT;
        end
        beat = {s_tdata, beat_last, beat_id, beat_dest};
    end

    // accept implies the skid register is empty, since rdy_q mirrors !skid_vld_q
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || m_tready) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_d = beat;
                end
            end
        end else if (accept) begin
            skid_d     = beat;
            skid_vld_d = 1'b1;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            remain_q   <= '0;
            id_q       <= '0;
            dest_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            id_q       <= id_d;
            dest_q     <= dest_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign s_tready = rdy_q;
    assign m_tvalid = main_vld_q;
    assign {m_tdata, m_tlast, m_tid, m_tdest} = main_q;
    assign m_tkeep  = {KW{main_vld_q}};
    assign m_tstrb  = {KW{main_vld_q}};

`ifdef PIRADIP_AXIS_FRAMER_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_short_q, stat_short_d;

    always_comb begin
        stat_pkts_d  = stat_pkts_q;
        stat_short_d = stat_short_q;
        if (main_vld_q && m_tready && m_tlast) begin
            stat_pkts_d = stat_pkts_q + 32'd1;
        end
        if (accept && s_tlast && !nat_last) begin
            stat_short_d = stat_short_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkts_q  <= '0;
            stat_short_q <= '0;
        end else begin
            stat_pkts_q  <= stat_pkts_d;
            stat_short_q <= stat_short_d;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_short = stat_short_q;
`endif

endmodule

// File: tb/tb_axis_framer.sv
// Scoreboard bench for axis_framer: a packet-level reference model predicts every
// output beat at input acceptance; a negedge monitor pops and compares on handshake.
module tb_axis_framer;

    localparam int W  = 32;
    localparam int LW = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         id;
        logic         dest;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic          pkt_id = 1'b0;
    logic          pkt_dest = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [W-1:0]  s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [W-1:0]  m_tdata;
    logic          m_tlast;
    logic [3:0]    m_tkeep;
    logic [3:0]    m_tstrb;
    logic          m_tid;
    logic          m_tdest;
`ifdef PIRADIP_AXIS_FRAMER_STATS_EN
    logic [31:0]   stat_pkts;
    logic [31:0]   stat_short;
`endif

    axis_framer #(.WIDTH(W), .LEN_WIDTH(LW), .ID_WIDTH(1), .DEST_WIDTH(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .pkt_len(pkt_len), .pkt_id(pkt_id), .pkt_dest(pkt_dest),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tkeep(m_tkeep), .m_tstrb(m_tstrb), .m_tid(m_tid), .m_tdest(m_tdest)
`ifdef PIRADIP_AXIS_FRAMER_STATS_EN
        , .stat_pkts(stat_pkts), .stat_short(stat_short)
`endif
    );

    always #5 aclk = ~aclk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    up = 0;
    int    rdy_mode = 0;
    int    pat_idx = 0;
    beat_t exp_q[$];
    beat_t out_log[$];
    int    out_cyc[$];
    int    acc_cyc[$];

    // reference model: packet-level bookkeeping
    bit    mdl_open = 0;
    int    mdl_pos = 0;
    int    mdl_len = 0;
    logic  mdl_id = 1'b0;
    logic  mdl_dest = 1'b0;

    bit    prev_hold = 0;
    beat_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept();
        beat_t e;
        if (!mdl_open) begin
            mdl_len  = (pkt_len == 0) ? (1 << LW) : int'(pkt_len);
            mdl_id   = pkt_id;
            mdl_dest = pkt_dest;
            mdl_pos  = 0;
        end
        e.data = s_tdata;
        e.last = (mdl_pos == mdl_len - 1) || s_tlast;
        e.id   = mdl_id;
        e.dest = mdl_dest;
        exp_q.push_back(e);
        if (e.last) mdl_open = 0;
        else begin
            mdl_open = 1;
            mdl_pos++;
        end
    endtask

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: begin
                m_tready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                pat_idx++;
            end
            2: m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
        endcase
    end

    always @(negedge aclk) begin
        beat_t got;
        cyc++;
        if (!aresetn) begin
            up = 0;
            prev_hold = 0;
        end else begin
            up++;
            got = {m_tdata, m_tlast, m_tid, m_tdest};
            if (s_tvalid && s_tready) begin
                model_accept();
                acc_cyc.push_back(cyc);
            end
            if (prev_hold) chk("stall_stable", {m_tvalid, got}, {1'b1, held});
            if (up >= 2 && !s_tready) chk("tready_low_main_full", m_tvalid, 1);
            chk("keep_strb", {m_tkeep, m_tstrb}, m_tvalid ? 8'hFF : 8'h00);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", got, 0);
                else chk("sb_beat", got, exp_q.pop_front());
                out_log.push_back(got);
                out_cyc.push_back(cyc);
            end
            prev_hold = m_tvalid && !m_tready;
            held = got;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic tl);
        bit ok = 0;
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = tl;
        while (!ok && n < 200) begin
            @(negedge aclk);
            ok = s_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic clear_log();
        out_log.delete();
        out_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic check_pkt(input string name, input int n, input int base, input logic [63:0] mask);
        logic [63:0] m;
        m = mask;
        chk({name, "_count"}, out_log.size(), n);
        for (int i = 0; i < n && i < out_log.size(); i++) begin
            chk({name, "_data"}, out_log[i].data, base + i);
            chk({name, "_last"}, out_log[i].last, m[i]);
        end
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        aresetn  = 1'b0;
        #1;
        chk("rst_outputs", {m_tvalid, m_tlast, m_tdata, m_tkeep, m_tstrb, m_tid, m_tdest, s_tready}, 0);
        exp_q.delete();
        mdl_open = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("tready_before_edge", s_tready, 0);
        @(posedge aclk);
        #1;
        chk("tready_after_edge", s_tready, 1);
        clear_log();
    endtask

    initial begin
        int nsent;
        rdy_mode = 0;
        #2;
        do_reset();

        // early terminate, then a full packet
        pkt_len = 4'd8;
        for (int i = 0; i < 11; i++) send(i, i == 2);
        drain();
        check_pkt("early", 11, 0, 64'h404);
`ifdef PIRADIP_AXIS_FRAMER_STATS_EN
        chk("stat_short", stat_short, 1);
        chk("stat_pkts", stat_pkts, 2);
`endif
        clear_log();

        // basic framing, latency and no bubbles
        pkt_len = 4'd4;
        for (int i = 0; i < 12; i++) send(i, 1'b0);
        drain();
        check_pkt("basic", 12, 0, 64'h888);
        if (out_cyc.size() == 12 && acc_cyc.size() == 12) begin
            chk("basic_latency", out_cyc[0], acc_cyc[0] + 1);
            chk("basic_no_bubble", out_cyc[11], out_cyc[0] + 11);
        end else chk("basic_logs", out_cyc.size(), 12);
        clear_log();

        // backpressure 1,0,0,1
        pat_idx = 0;
        rdy_mode = 1;
        pkt_len = 4'd3;
        for (int i = 0; i < 9; i++) send(i, 1'b0);
        drain();
        check_pkt("bp", 9, 0, 64'h124);
        rdy_mode = 0;
        idle(2);
        clear_log();

        // length 1
        pkt_len = 4'd1;
        for (int i = 0; i < 6; i++) send(i, 1'b0);
        drain();
        check_pkt("len1", 6, 0, 64'h3F);
        clear_log();

        // length 0 -> 16 beats
        pkt_len = 4'd0;
        for (int i = 0; i < 32; i++) send(i, 1'b0);
        drain();
        check_pkt("len0", 32, 0, 64'h80008000);
        clear_log();

        // length change mid-packet
        pkt_len = 4'd4;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) pkt_len = 4'd2;
            send(i, 1'b0);
        end
        drain();
        check_pkt("lenchg", 6, 0, 64'h28);
        clear_log();

        // tags sampled at packet start
        pkt_len = 4'd4;
        pkt_id = 1'b1;
        pkt_dest = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                pkt_id = 1'b0;
                pkt_dest = 1'b1;
            end
            send(i, 1'b0);
        end
        drain();
        check_pkt("tags", 8, 0, 64'h88);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("tags_id_dest", {out_log[i].id, out_log[i].dest}, (i < 4) ? 2'b10 : 2'b01);
        clear_log();

        // reset with main and skid both holding beats
        rdy_mode = 3;
        idle(1);
        pkt_len = 4'd4;
        send(100, 1'b0);
        send(101, 1'b0);
        s_tvalid = 1'b1;
        s_tdata = 102;
        @(negedge aclk);
        chk("mid_tready_low", s_tready, 0);
        @(posedge aclk);
        #1;
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) send(200 + i, 1'b0);
        drain();
        check_pkt("post_rst", 4, 200, 64'h8);
        clear_log();

        // randomized traffic
        rdy_mode = 2;
        nsent = 0;
        for (int i = 0; i < 300; i++) begin
            pkt_len  = 4'($urandom_range(0, 15));
            pkt_id   = 1'($urandom_range(0, 1));
            pkt_dest = 1'($urandom_range(0, 1));
            send($urandom, ($urandom_range(0, 9) == 0));
            nsent++;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        chk("rand_count", out_log.size(), nsent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
